// File: rtl/round_key_store.sv
// round_key_store: buffers the 16 round keys from ROUND_KEY and serves them
// to the round core in forward or reverse order.
module round_key_store #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_W      = 96,
  parameter int IDX_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] Key_in,
  input  logic             Key_valid,
  input  logic             Key_done,
  input  logic             Start,
  input  logic             Decrypt,
  input  logic             Round_req,
  output logic [KEY_W-1:0] Round_key,
  output logic [IDX_W-1:0] Round_idx,
  output logic             Round_valid,
  output logic             Last_round,
  output logic             Key_ready,
  output logic             Err_short,
  output logic             Err_overflow
);
  typedef enum logic [1:0] {EMPTY, LOAD, READY, SERVE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);
  state_t           r_state, w_next;
  logic [KEY_W-1:0] r_mem [NUM_ROUNDS];
  logic [KEY_W-1:0] r_key;
  logic [IDX_W-1:0] r_ptr, r_idx, w_nidx, w_end, w_waddr;
  logic             r_dec, r_err_short, r_err_ovf;
  logic             w_we, w_wr_last, w_start, w_adv;
  assign w_we      = Key_valid && r_state != SERVE;
  assign w_waddr   = r_state == LOAD ? r_ptr : '0;
  assign w_wr_last = r_state == LOAD && Key_valid && r_ptr == LAST;
  assign w_start   = r_state == READY && Start && !Key_valid;
  assign w_end     = r_dec ? '0 : LAST;
  assign w_adv     = r_state == SERVE && Round_req && r_idx != w_end;
  assign w_nidx    = w_start ? (Decrypt ? LAST : '0) : r_dec ? r_idx - 1'b1 : r_idx + 1'b1;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_key       <= '0;
      r_dec       <= 1'b0;
      r_err_short <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == EMPTY) r_ptr <= '0;
      else if (w_we) r_ptr <= w_waddr + 1'b1;
      if (w_start) r_dec <= Decrypt;
      if (w_start || w_adv) begin
        r_idx <= w_nidx;
        r_key <= r_mem[w_nidx];
      end
      if (Key_done && (r_state == EMPTY || (r_state == LOAD && !w_wr_last))) r_err_short <= 1'b1;
      if (r_state == SERVE && Key_valid) r_err_ovf <= 1'b1;
    end
  end
  // storage carries no reset; a full reload is always required before serving
  always_ff @(posedge Clk) begin
    if (Reset && w_we) r_mem[w_waddr] <= Key_in;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = (Key_valid && !Key_done) ? LOAD : EMPTY;
      LOAD:    w_next = (Key_done && !w_wr_last) ? EMPTY : w_wr_last ? READY : LOAD;
      READY:   w_next = Key_valid ? LOAD : Start ? SERVE : READY;
      SERVE:   w_next = (Round_req && r_idx == w_end) ? READY : SERVE;
      default: w_next = EMPTY;
    endcase
  end
  always_comb begin
    Round_key    = r_key;
    Round_idx    = r_idx;
    Round_valid  = r_state == SERVE;
    Last_round   = r_state == SERVE && r_idx == w_end;
    Key_ready    = r_state == READY;
    Err_short    = r_err_short;
    Err_overflow = r_err_ovf;
  end
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed sequence with random keys, checked against an
// array model of the stored key set and the expected serve order.
module tb_round_key_store;
  localparam int N = 16;
  localparam int KW = 96;
  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [KW-1:0] Key_in = '0;
  logic          Key_valid = 1'b0, Key_done = 1'b0, Start = 1'b0, Decrypt = 1'b0, Round_req = 1'b0;
  logic [KW-1:0] Round_key;
  logic [3:0]    Round_idx;
  logic          Round_valid, Last_round, Key_ready, Err_short, Err_overflow;
  int            checks = 0, failures = 0;
  logic [KW-1:0] exp_mem [N];
  logic [KW-1:0] tmp [N];
  logic          exp_short = 1'b0, exp_ovf = 1'b0;

  round_key_store dut (
    .Clk(Clk), .Reset(Reset), .Key_in(Key_in), .Key_valid(Key_valid), .Key_done(Key_done),
    .Start(Start), .Decrypt(Decrypt), .Round_req(Round_req), .Round_key(Round_key),
    .Round_idx(Round_idx), .Round_valid(Round_valid), .Last_round(Last_round),
    .Key_ready(Key_ready), .Err_short(Err_short), .Err_overflow(Err_overflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, Round_valid, 0);
    chk({tag, "_last"}, Last_round, 0);
    chk({tag, "_short"}, Err_short, exp_short);
    chk({tag, "_ovf"}, Err_overflow, exp_ovf);
  endtask

  // Writes keys first..first+n-1; a complete set becomes the expected store.
  task automatic load(input int first, input int n, input bit rnd, input bit done_last);
    logic [3:0] v;
    for (int i = first; i < first + n; i++) begin
      v = 4'(i);
      Key_valid = 1'b1;
      Key_in = rnd ? {$urandom(), $urandom(), $urandom()} : {24{v}};
      Key_done = done_last && i == first + n - 1;
      tmp[i] = Key_in;
      tick();
      if (i == N - 2) chk("ready_before_last", Key_ready, 0);
    end
    Key_valid = 1'b0;
    Key_done = 1'b0;
    if (first + n == N) for (int i = 0; i < N; i++) exp_mem[i] = tmp[i];
    else if (done_last) exp_short = 1'b1;
    chk("ready_after_load", Key_ready, first + n == N);
    chk("err_short", Err_short, exp_short);
  endtask

  // Serves a full sequence; optional overflow pulse or reset at step k.
  task automatic serve(input bit dec, input int ovf_at, input int rst_at);
    int e;
    Start = 1'b1;
    Decrypt = dec;
    tick();
    Start = 1'b0;
    Decrypt = 1'($urandom());
    for (int k = 0; k < N; k++) begin
      e = dec ? N - 1 - k : k;
      chk("valid", Round_valid, 1);
      chk("idx", Round_idx, e);
      chk("key", Round_key, exp_mem[e]);
      chk("last", Last_round, k == N - 1);
      chk("ready_in_serve", Key_ready, 0);
      if (k == rst_at) begin
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        exp_short = 1'b0;
        exp_ovf = 1'b0;
        chk("rst_key", Round_key, 0);
        chk("rst_idx", Round_idx, 0);
        chk("rst_ready", Key_ready, 0);
        chk_idle("rst");
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        Start = 1'($urandom());
        tick();
        Start = 1'b0;
        chk("hold_idx", Round_idx, e);
        chk("hold_key", Round_key, exp_mem[e]);
      end
      Round_req = 1'b1;
      if (k == ovf_at) begin
        Key_valid = 1'b1;
        Key_in = {3{32'hDEADBEEF}};
        exp_ovf = 1'b1;
      end
      tick();
      Round_req = 1'b0;
      Key_valid = 1'b0;
      if (k == ovf_at) chk("err_ovf", Err_overflow, 1);
    end
    chk_idle("done");
    chk("done_ready", Key_ready, 1);
    chk("done_idx", Round_idx, dec ? 0 : N - 1);
    chk("done_key", Round_key, exp_mem[dec ? 0 : N - 1]);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_key", Round_key, 0);
    chk("reset_idx", Round_idx, 0);
    chk("reset_ready", Key_ready, 0);
    chk_idle("reset");
    Reset = 1'b1;
    tick();
    load(0, N, 1'b0, 1'b1);
    chk("pattern_k15", exp_mem[15], {24{4'hF}});
    Round_req = 1'b1;
    tick();
    Round_req = 1'b0;
    chk("req_in_ready_idx", Round_idx, 0);
    chk_idle("req_in_ready");
    serve(1'b0, -1, -1);
    serve(1'b1, -1, -1);
    load(0, 10, 1'b1, 1'b1);
    chk_idle("short");
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_in_empty", Round_valid, 0);
    load(0, N, 1'b1, 1'b0);
    serve(1'($urandom()), -1, -1);
    Key_valid = 1'b1;
    Start = 1'b1;
    Key_in = {$urandom(), $urandom(), $urandom()};
    tmp[0] = Key_in;
    tick();
    Key_valid = 1'b0;
    Start = 1'b0;
    chk("reload_wins_ready", Key_ready, 0);
    chk("reload_wins_valid", Round_valid, 0);
    load(1, N - 1, 1'b1, 1'b1);
    serve(1'b0, $urandom_range(2, 12), -1);
    serve(1'b1, -1, -1);
    serve(1'b0, -1, 7);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_after_reset", Round_valid, 0);
    chk("ready_after_reset", Key_ready, 0);
    load(0, N, 1'b1, 1'b1);
    serve(1'b1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
